// File: rtl/reg_scoreboard.sv
// Register scoreboard for an in-order issue stage.
// Tracks destination registers with writes in flight (pending vector) and
// reserves the single writeback port per future cycle (slots vector), so an
// instruction issues only when its operands are ready, it cannot overtake an
// older write to the same register, and its writeback cycle is free.
module reg_scoreboard #(
    parameter int AM_LAT  = 4,
    parameter int MEM_LAT = 3,
    parameter int MUL_LAT = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iss_sb_valid,
    input  logic [4:0]  iss_sb_addra,
    input  logic [4:0]  iss_sb_addrb,
    input  logic [4:0]  iss_sb_regdest,
    input  logic        iss_sb_writereg,
    input  logic [1:0]  iss_sb_unit,
    output logic        sb_iss_stall,
    output logic        sb_iss_accept,
    input  logic        wb_sb_en,
    input  logic [4:0]  wb_sb_addr,
    output logic [31:0] sb_pending,
    output logic [7:0]  sb_slots,
    output logic [5:0]  sb_busy_count
);

    logic [3:0]  lat;
    logic [3:0]  lat_m1;
    logic        unit_illegal;
    logic        raw_a;
    logic        raw_b;
    logic        waw;
    logic        slot_hit;
    logic [7:0]  resv;
    logic [7:0]  slots_nxt;
    logic [31:0] pend_nxt;

    // Writeback latency of the unit the instruction is steered to; 0 for the
    // illegal encoding, which is stalled unconditionally.
    always_comb begin
        lat = 4'd0;
        case (iss_sb_unit)
            2'd0:    lat = 4'(AM_LAT);
            2'd1:    lat = 4'(MEM_LAT);
            2'd2:    lat = 4'(MUL_LAT);
            default: lat = 4'd0;
        endcase
    end

    assign lat_m1       = lat - 4'd1;
    assign unit_illegal = (iss_sb_unit == 2'd3);

    // Hazard detection looks only at registered state; a writeback in the
    // same cycle does not release a dependent instruction until next cycle.
    always_comb begin
        raw_a    = (iss_sb_addra != 5'd0) && sb_pending[iss_sb_addra];
        raw_b    = (iss_sb_addrb != 5'd0) && sb_pending[iss_sb_addrb];
        waw      = iss_sb_writereg && (iss_sb_regdest != 5'd0) && sb_pending[iss_sb_regdest];
        slot_hit = iss_sb_writereg && !unit_illegal && sb_slots[lat_m1[2:0]];
    end

    // Stall and accept are forced low while reset is held.
    assign sb_iss_stall  = reset && iss_sb_valid &&
                           (raw_a || raw_b || waw || slot_hit || unit_illegal);
    assign sb_iss_accept = reset && iss_sb_valid && !sb_iss_stall;

    // Reservation is made at bit L-1 so that after the shift it sits L-1
    // cycles ahead; bit 0 leaving the vector marks the writeback cycle.
    always_comb begin
        resv = 8'd0;
        if (sb_iss_accept && iss_sb_writereg) begin
            resv = 8'd1 << lat_m1[2:0];
        end
        slots_nxt = (sb_slots | resv) >> 1;
    end

    // Next pending vector: clear first so a same-cycle set wins; r0 never pends.
    always_comb begin
        pend_nxt = sb_pending;
        if (wb_sb_en && (wb_sb_addr != 5'd0)) begin
            pend_nxt[wb_sb_addr] = 1'b0;
        end
        if (sb_iss_accept && iss_sb_writereg && (iss_sb_regdest != 5'd0)) begin
            pend_nxt[iss_sb_regdest] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard state registers, cleared asynchronously on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_pending <= 32'h0;
            sb_slots   <= 8'h0;
        end else begin
            sb_pending <= pend_nxt;
            sb_slots   <= slots_nxt;
        end
    end

    // Number of registers with a write in flight.
    always_comb begin
        sb_busy_count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            sb_busy_count = sb_busy_count + {5'd0, sb_pending[i]};
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. dut1 uses default latencies
// (AluMisc 4, Mem 3, Mult 5); dut2 uses a Mult latency of 6 so that a
// reservation pattern of 8'h16 can be built, and has its own valid input.
module tb_reg_scoreboard;

    logic        clock;
    logic        reset;
    logic        valid;
    logic        valid2;
    logic [4:0]  addra;
    logic [4:0]  addrb;
    logic [4:0]  regdest;
    logic        writereg;
    logic [1:0]  unit;
    logic        wb_en;
    logic [4:0]  wb_addr;

    logic        stall;
    logic        accept;
    logic [31:0] pending;
    logic [7:0]  slots;
    logic [5:0]  busy;

    logic        stall2;
    logic        accept2;
    logic [31:0] pending2;
    logic [7:0]  slots2;
    logic [5:0]  busy2;

    int compared   = 0;
    int mismatched = 0;

    reg_scoreboard dut1 (
        .clock          (clock),
        .reset          (reset),
        .iss_sb_valid   (valid),
        .iss_sb_addra   (addra),
        .iss_sb_addrb   (addrb),
        .iss_sb_regdest (regdest),
        .iss_sb_writereg(writereg),
        .iss_sb_unit    (unit),
        .sb_iss_stall   (stall),
        .sb_iss_accept  (accept),
        .wb_sb_en       (wb_en),
        .wb_sb_addr     (wb_addr),
        .sb_pending     (pending),
        .sb_slots       (slots),
        .sb_busy_count  (busy)
    );

    reg_scoreboard #(.AM_LAT(4), .MEM_LAT(3), .MUL_LAT(6)) dut2 (
        .clock          (clock),
        .reset          (reset),
        .iss_sb_valid   (valid2),
        .iss_sb_addra   (addra),
        .iss_sb_addrb   (addrb),
        .iss_sb_regdest (regdest),
        .iss_sb_writereg(writereg),
        .iss_sb_unit    (unit),
        .sb_iss_stall   (stall2),
        .sb_iss_accept  (accept2),
        .wb_sb_en       (wb_en),
        .wb_sb_addr     (wb_addr),
        .sb_pending     (pending2),
        .sb_slots       (slots2),
        .sb_busy_count  (busy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic v, input logic [1:0] u, input logic [4:0] rd,
                         input logic [4:0] a, input logic [4:0] b, input logic wr);
        valid    = v;
        unit     = u;
        regdest  = rd;
        addra    = a;
        addrb    = b;
        writereg = wr;
    endtask

    task automatic wb(input logic en, input logic [4:0] addr);
        wb_en   = en;
        wb_addr = addr;
    endtask

    initial begin
        reset  = 1'b0;
        valid2 = 1'b0;
        issue(1'b1, 2'd3, 5'd1, 5'd0, 5'd0, 1'b1);
        wb(1'b0, 5'd0);
        #12;
        // reset state
        check("rst_stall",   32'(stall),   32'h0);
        check("rst_accept",  32'(accept),  32'h0);
        check("rst_pending", pending,      32'h0);
        check("rst_slots",   32'(slots),   32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        reset = 1'b1;
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();

        // AluMisc write of r5, RAW stalls, writeback clears
        issue(1'b1, 2'd0, 5'd5, 5'd0, 5'd0, 1'b1);
        #1;
        check("t34_accept", 32'(accept), 32'h1);
        check("t34_stall0", 32'(stall),  32'h0);
        step();
        check("t34_pending", pending,    32'h20);
        check("t34_slots",   32'(slots), 32'h04);
        check("t34_busy",    32'(busy),  32'h1);
        issue(1'b1, 2'd0, 5'd0, 5'd5, 5'd0, 1'b0);
        #1;
        check("t34_raw_a_stall",  32'(stall),  32'h1);
        check("t34_raw_a_accept", 32'(accept), 32'h0);
        issue(1'b1, 2'd0, 5'd0, 5'd0, 5'd5, 1'b0);
        #1;
        check("t34_raw_b_stall", 32'(stall), 32'h1);
        issue(1'b0, 2'd0, 5'd0, 5'd5, 5'd0, 1'b0);
        #1;
        check("t34_idle_stall", 32'(stall), 32'h0);
        step();
        check("t34_slots_t2", 32'(slots), 32'h02);
        step();
        check("t34_slots_t3", 32'(slots), 32'h01);
        step();
        check("t34_slots_t4", 32'(slots), 32'h00);
        wb(1'b1, 5'd5);
        issue(1'b1, 2'd0, 5'd0, 5'd5, 5'd0, 1'b0);
        #1;
        check("t34_no_bypass", 32'(stall), 32'h1);
        step();
        check("t34_pending_clr", pending,   32'h0);
        check("t34_busy_clr",    32'(busy), 32'h0);
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0);

        // Mult then AluMisc: writeback-port conflict, retry accepts
        issue(1'b1, 2'd2, 5'd10, 5'd0, 5'd0, 1'b1);
        #1;
        check("t35_mul_accept", 32'(accept), 32'h1);
        step();
        check("t35_slots1", 32'(slots), 32'h08);
        issue(1'b1, 2'd0, 5'd11, 5'd0, 5'd0, 1'b1);
        #1;
        check("t35_slot_stall", 32'(stall), 32'h1);
        step();
        check("t35_slots2", 32'(slots), 32'h04);
        #1;
        check("t35_retry_accept", 32'(accept), 32'h1);
        step();
        check("t35_slots3",  32'(slots), 32'h06);
        check("t35_pending", pending,    32'hC00);
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b1, 5'd10);
        step();
        wb(1'b1, 5'd11);
        step();
        check("t35_pending_clr", pending, 32'h0);
        wb(1'b0, 5'd0);
        step();
        check("t35_slots_drain", 32'(slots), 32'h00);

        // WAW stall; regdest 0 reserves a slot without a pending bit
        issue(1'b1, 2'd1, 5'd7, 5'd0, 5'd0, 1'b1);
        #1;
        check("t36_mem_accept", 32'(accept), 32'h1);
        step();
        check("t36_pending7", pending,    32'h80);
        check("t36_slots1",   32'(slots), 32'h02);
        issue(1'b1, 2'd0, 5'd7, 5'd0, 5'd0, 1'b1);
        #1;
        check("t36_waw_stall", 32'(stall), 32'h1);
        issue(1'b1, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        check("t36_r0_accept", 32'(accept), 32'h1);
        step();
        check("t36_r0_pending", pending,    32'h80);
        check("t36_r0_slots",   32'(slots), 32'h05);
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b1, 5'd7);
        step();
        check("t36_pending_clr", pending, 32'h0);
        wb(1'b0, 5'd0);
        step();
        step();
        check("t36_slots_drain", 32'(slots), 32'h00);

        // set wins over same-cycle clear; writeback to r0 is ignored
        issue(1'b1, 2'd0, 5'd9, 5'd0, 5'd0, 1'b1);
        wb(1'b1, 5'd9);
        #1;
        check("t37_accept", 32'(accept), 32'h1);
        step();
        check("t37_set_wins", pending,    32'h200);
        check("t37_slots",    32'(slots), 32'h04);
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b1, 5'd0);
        step();
        check("t37_wb_r0", pending, 32'h200);
        wb(1'b1, 5'd9);
        step();
        check("t37_pending_clr", pending, 32'h0);
        wb(1'b0, 5'd0);
        step();

        // illegal unit always stalls and changes nothing
        issue(1'b1, 2'd3, 5'd12, 5'd0, 5'd0, 1'b1);
        #1;
        check("t38_stall",  32'(stall),  32'h1);
        check("t38_accept", 32'(accept), 32'h0);
        step();
        check("t38_pending", pending,    32'h0);
        check("t38_slots",   32'(slots), 32'h0);
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);

        // build slots=8'h16 on dut2, reset mid-cycle, then fresh accept
        valid2 = 1'b1;
        unit = 2'd2; regdest = 5'd1; writereg = 1'b1;
        #1;
        check("t39_acc1", 32'(accept2), 32'h1);
        step();
        unit = 2'd0; regdest = 5'd2;
        #1;
        check("t39_acc2", 32'(accept2), 32'h1);
        step();
        unit = 2'd2; regdest = 5'd4;
        #1;
        check("t39_acc3", 32'(accept2), 32'h1);
        step();
        valid2 = 1'b0;
        check("t39_pending_pre", pending2,    32'h16);
        check("t39_slots_pre",   32'(slots2), 32'h16);
        check("t39_busy_pre",    32'(busy2),  32'h3);
        #2;
        reset = 1'b0;
        #1;
        check("t39_pending_rst", pending2,    32'h0);
        check("t39_slots_rst",   32'(slots2), 32'h0);
        check("t39_busy_rst",    32'(busy2),  32'h0);
        valid2 = 1'b1;
        unit = 2'd1; regdest = 5'd3; writereg = 1'b1;
        #1;
        check("t39_stall_in_rst",  32'(stall2),  32'h0);
        check("t39_accept_in_rst", 32'(accept2), 32'h0);
        #1;
        reset = 1'b1;
        #1;
        check("t39_accept_after", 32'(accept2), 32'h1);
        step();
        check("t39_slots_after",   32'(slots2), 32'h02);
        check("t39_pending_after", pending2,    32'h08);
        valid2 = 1'b0;
        writereg = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
